// File: rtl/piano_input_ctrl_if.sv
// rtl/piano_input_ctrl_if.sv - raw UI inputs and conditioned note/octave/ADSR outputs of piano_input_ctrl
interface piano_input_ctrl_if;
    logic [11:0] iKeys;
    logic        iOctUp;
    logic        iOctDown;
    logic        iAdsrUp;
    logic        iAdsrDown;
    logic        iAdsrNext;
    logic [3:0]  note;
    logic        note_in;
    logic        octave_plus_plus;
    logic        octave_minus_minus;
    logic        ADSR_plus_plus;
    logic        ADSR_minus_minus;
    logic [2:0]  ADSR_selector;
    logic [2:0]  oOctave;
    logic [15:0] oAdsrLevels;

    modport master (
        output iKeys, iOctUp, iOctDown, iAdsrUp, iAdsrDown, iAdsrNext,
        input  note, note_in, octave_plus_plus, octave_minus_minus,
               ADSR_plus_plus, ADSR_minus_minus, ADSR_selector, oOctave, oAdsrLevels
    );

    modport slave (
        input  iKeys, iOctUp, iOctDown, iAdsrUp, iAdsrDown, iAdsrNext,
        output note, note_in, octave_plus_plus, octave_minus_minus,
               ADSR_plus_plus, ADSR_minus_minus, ADSR_selector, oOctave, oAdsrLevels
    );
endinterface

// File: rtl/piano_input_ctrl.sv
// rtl/piano_input_ctrl.sv - key/button sync+debounce, note encoder, octave and ADSR level control
// Optional build macro PULSE_STRETCH_EN stretches the ++/-- outputs to STRETCH_CYCLES cycles.
module piano_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int OCT_MIN         = 0,
    parameter int OCT_MAX         = 7,
    parameter int OCT_RESET       = 4,
    parameter int LEVEL_RESET     = 8,
    parameter int STRETCH_CYCLES  = 32
) (
    input logic             iClock,
    input logic             iReset,
    piano_input_ctrl_if.slave bus
);
    localparam int NIN = 17;
    localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);

    logic [NIN-1:0] raw, sync1, sync2, stable, stable_q, rise;
    logic [CW-1:0]  db_cnt [NIN];

    logic [3:0]  note_r, enc;
    logic        note_in_r;
    logic [2:0]  octave;
    logic [1:0]  adsr_sel;
    logic [15:0] levels;
    logic [3:0]  cur_lev;
    logic [3:0]  evt, pulse_q;
    logic        oct_up, oct_dn, lev_up, lev_dn, next_ev;
    logic        oct_inc, oct_dec, lev_inc, lev_dec;

    // bits 0..11 keys, 12 oct up, 13 oct down, 14 adsr up, 15 adsr down, 16 adsr next
    assign raw = {bus.iAdsrNext, bus.iAdsrDown, bus.iAdsrUp, bus.iOctDown, bus.iOctUp, bus.iKeys};

    always_ff @(posedge iClock) begin
        if (iReset) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_q <= '0;
            for (int i = 0; i < NIN; i++) db_cnt[i] <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_q <= stable;
            for (int i = 0; i < NIN; i++) begin
                if (sync2[i] != stable[i]) begin
                    if (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                        stable[i] <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign rise    = stable & ~stable_q;
    assign oct_up  = rise[12];
    assign oct_dn  = rise[13];
    assign lev_up  = rise[14];
    assign lev_dn  = rise[15];
    assign next_ev = rise[16];

    assign cur_lev = levels[{adsr_sel, 2'b00} +: 4];
    // Simultaneous up and down requests cancel each other.
    assign oct_inc = oct_up & ~oct_dn & (octave < 3'(OCT_MAX));
    assign oct_dec = oct_dn & ~oct_up & (octave > 3'(OCT_MIN));
    assign lev_inc = lev_up & ~lev_dn & (cur_lev != 4'hF);
    assign lev_dec = lev_dn & ~lev_up & (cur_lev != 4'h0);
    assign evt     = {lev_dec, lev_inc, oct_dec, oct_inc};

    always_comb begin
        enc = note_r;
        for (int i = 11; i >= 0; i--) begin
            if (stable[i]) enc = 4'(i);
        end
    end

`ifdef PULSE_STRETCH_EN
    localparam int SW = $clog2(STRETCH_CYCLES + 1);
    logic [SW-1:0] st_cnt [4];
`endif

    always_ff @(posedge iClock) begin
        if (iReset) begin
            note_r    <= '0;
            note_in_r <= 1'b0;
            octave    <= 3'(OCT_RESET);
            adsr_sel  <= '0;
            levels    <= {4{4'(LEVEL_RESET)}};
            pulse_q   <= '0;
`ifdef PULSE_STRETCH_EN
            for (int i = 0; i < 4; i++) st_cnt[i] <= '0;
`endif
        end else begin
            note_r    <= enc;
            note_in_r <= |stable[11:0];
            if (oct_inc) octave <= octave + 3'd1;
            else if (oct_dec) octave <= octave - 3'd1;
            // Level change uses the pre-advance selector when Next coincides.
            if (lev_inc) levels[{adsr_sel, 2'b00} +: 4] <= cur_lev + 4'd1;
            else if (lev_dec) levels[{adsr_sel, 2'b00} +: 4] <= cur_lev - 4'd1;
            if (next_ev) adsr_sel <= adsr_sel + 2'd1;
`ifdef PULSE_STRETCH_EN
            for (int i = 0; i < 4; i++) begin
                if (evt[i]) begin
                    pulse_q[i] <= 1'b1;
                    st_cnt[i]  <= SW'(STRETCH_CYCLES - 1);
                end else if (evt[i ^ 1]) begin
                    pulse_q[i] <= 1'b0;
                    st_cnt[i]  <= '0;
                end else if (st_cnt[i] != '0) begin
                    st_cnt[i]  <= st_cnt[i] - 1'b1;
                end else begin
                    pulse_q[i] <= 1'b0;
                end
            end
`else
            pulse_q <= evt;
`endif
        end
    end

    assign bus.note               = note_r;
    assign bus.note_in            = note_in_r;
    assign bus.octave_plus_plus   = pulse_q[0];
    assign bus.octave_minus_minus = pulse_q[1];
    assign bus.ADSR_plus_plus     = pulse_q[2];
    assign bus.ADSR_minus_minus   = pulse_q[3];
    assign bus.ADSR_selector      = {1'b0, adsr_sel};
    assign bus.oOctave            = octave;
    assign bus.oAdsrLevels        = levels;
endmodule

// File: tb/tb_piano_input_ctrl.sv
// tb/tb_piano_input_ctrl.sv - directed self-checking bench for piano_input_ctrl (DEBOUNCE_CYCLES=4)
module tb_piano_input_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_oct_pp = 0;
    int   n_adsr_mm = 0;

    piano_input_ctrl_if ifc ();

    piano_input_ctrl #(.DEBOUNCE_CYCLES(4), .STRETCH_CYCLES(32)) dut (
        .iClock (clk),
        .iReset (rst),
        .bus    (ifc)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ifc.octave_plus_plus === 1'b1) n_oct_pp++;
        if (ifc.ADSR_minus_minus === 1'b1) n_adsr_mm++;
    end

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        ifc.iKeys = '0;
        ifc.iOctUp = 1'b0;
        ifc.iOctDown = 1'b0;
        ifc.iAdsrUp = 1'b0;
        ifc.iAdsrDown = 1'b0;
        ifc.iAdsrNext = 1'b0;
        tick(2);
        chk("rst_note", ifc.note, 0);
        chk("rst_note_in", ifc.note_in, 0);
        chk("rst_octave", ifc.oOctave, 4);
        chk("rst_levels", ifc.oAdsrLevels, 16'h8888);
        chk("rst_sel", ifc.ADSR_selector, 0);
        chk("rst_pulses", {ifc.octave_plus_plus, ifc.octave_minus_minus,
                           ifc.ADSR_plus_plus, ifc.ADSR_minus_minus}, 0);
        rst = 1'b0;
        tick(1);

`ifdef PULSE_STRETCH_EN
        ifc.iOctDown = 1'b1;
        tick(6);
        chk("st_pre", ifc.octave_minus_minus, 0);
        tick(1);
        chk("st_first", ifc.octave_minus_minus, 1);
        chk("st_oct", ifc.oOctave, 3);
        ifc.iOctDown = 1'b0;
        tick(31);
        chk("st_last", ifc.octave_minus_minus, 1);
        tick(1);
        chk("st_end", ifc.octave_minus_minus, 0);
        tick(4);
        ifc.iOctDown = 1'b1;
        tick(7);
        chk("st2_first", ifc.octave_minus_minus, 1);
        chk("st2_oct", ifc.oOctave, 2);
        ifc.iOctDown = 1'b0;
        tick(10);
        rst = 1'b1;
        tick(1);
        chk("st_rst_pulse", ifc.octave_minus_minus, 0);
        chk("st_rst_oct", ifc.oOctave, 4);
        rst = 1'b0;
        tick(2);
`else
        // single key: D+3 = 7 cycles each way, note holds on release
        ifc.iKeys = 12'h020;
        tick(6);
        chk("k5_early", ifc.note_in, 0);
        tick(1);
        chk("k5_note_in", ifc.note_in, 1);
        chk("k5_note", ifc.note, 5);
        ifc.iKeys = 12'h000;
        tick(6);
        chk("k5_rel_early", ifc.note_in, 1);
        tick(1);
        chk("k5_rel_note_in", ifc.note_in, 0);
        chk("k5_rel_note", ifc.note, 5);

        // bounce key 2
        for (int b = 0; b < 10; b++) begin
            ifc.iKeys = 12'h004;
            tick(1);
            ifc.iKeys = 12'h000;
            tick(1);
            chk("bounce_note_in", ifc.note_in, 0);
        end
        tick(10);
        chk("bounce_settle", ifc.note_in, 0);
        chk("bounce_note", ifc.note, 5);

        // priority: 7 held, add 3, release 3
        ifc.iKeys = 12'h080;
        tick(7);
        chk("k7_note", ifc.note, 7);
        ifc.iKeys = 12'h088;
        for (int c = 0; c < 7; c++) begin
            tick(1);
            chk("k73_note_in", ifc.note_in, 1);
        end
        chk("k73_note", ifc.note, 3);
        ifc.iKeys = 12'h080;
        tick(7);
        chk("k7_back", ifc.note, 7);
        chk("k7_back_in", ifc.note_in, 1);
        ifc.iKeys = 12'h000;
        tick(8);

        // octave up x5 from reset
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        n_oct_pp = 0;
        for (int p = 0; p < 5; p++) begin
            ifc.iOctUp = 1'b1;
            tick(6);
            chk("oup_pre", ifc.octave_plus_plus, 0);
            tick(1);
            chk("oup_oct", ifc.oOctave, (p < 3) ? 5 + p : 7);
            chk("oup_pulse", ifc.octave_plus_plus, (p < 3) ? 1 : 0);
            tick(1);
            chk("oup_width", ifc.octave_plus_plus, 0);
            ifc.iOctUp = 1'b0;
            tick(8);
        end
        chk("oup_count", n_oct_pp, 3);

        // ADSR: next twice, down x9 on stage S
        for (int s = 1; s <= 2; s++) begin
            ifc.iAdsrNext = 1'b1;
            tick(7);
            chk("next_sel", ifc.ADSR_selector, s);
            ifc.iAdsrNext = 1'b0;
            tick(8);
        end
        n_adsr_mm = 0;
        for (int d = 0; d < 9; d++) begin
            ifc.iAdsrDown = 1'b1;
            tick(7);
            chk("adn_levels", ifc.oAdsrLevels,
                {4'h8, (d < 8) ? 4'(7 - d) : 4'h0, 4'h8, 4'h8});
            chk("adn_pulse", ifc.ADSR_minus_minus, (d < 8) ? 1 : 0);
            ifc.iAdsrDown = 1'b0;
            tick(8);
        end
        chk("adn_count", n_adsr_mm, 8);
        chk("adn_sel", ifc.ADSR_selector, 2);

        // simultaneous octave up+down: ignored
        ifc.iOctUp = 1'b1;
        ifc.iOctDown = 1'b1;
        tick(7);
        chk("both_oct", ifc.oOctave, 7);
        chk("both_pulses", {ifc.octave_plus_plus, ifc.octave_minus_minus}, 0);
        ifc.iOctUp = 1'b0;
        ifc.iOctDown = 1'b0;
        tick(8);

        // Next + Up together: old stage (S) incremented, then selector advances
        ifc.iAdsrNext = 1'b1;
        ifc.iAdsrUp = 1'b1;
        tick(7);
        chk("nu_levels", ifc.oAdsrLevels, 16'h8188);
        chk("nu_sel", ifc.ADSR_selector, 3);
        chk("nu_pulse", ifc.ADSR_plus_plus, 1);
        ifc.iAdsrNext = 1'b0;
        ifc.iAdsrUp = 1'b0;
        tick(8);

        // key held through reset must be debounced again
        ifc.iKeys = 12'h200;
        tick(8);
        chk("k9_note", ifc.note, 9);
        rst = 1'b1;
        tick(2);
        chk("k9_rst_in", ifc.note_in, 0);
        chk("k9_rst_note", ifc.note, 0);
        rst = 1'b0;
        tick(6);
        chk("k9_post_early", ifc.note_in, 0);
        tick(1);
        chk("k9_post_in", ifc.note_in, 1);
        chk("k9_post_note", ifc.note, 9);
        ifc.iKeys = 12'h000;
        tick(2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
